// File: rtl/rategen_pkg.sv
// Shared constants for the multi-channel sample-rate generator.
package rategen_pkg;
  localparam int DIV_INIT_DEF = 384;
  localparam int DIV_MIN      = 2;
  localparam int CHW          = 3;
endpackage

// File: rtl/rategen_if.sv
// Control/strobe bundle for rategen_mc: per-channel enables, sync, divisor writes, rate outputs.
interface rategen_if #(
  parameter int NCH = 2,
  parameter int CW  = 9,
  parameter int FW  = 8
);
  logic [NCH-1:0]               en;
  logic                         sync;
  logic                         div_wr;
  logic [rategen_pkg::CHW-1:0]  div_ch;
  logic [CW-1:0]                div_val;
  logic [FW-1:0]                div_frac;
  logic [NCH-1:0]               rate;

  modport master (output en, sync, div_wr, div_ch, div_val, div_frac, input rate);
  modport slave  (input en, sync, div_wr, div_ch, div_val, div_frac, output rate);
endinterface

// File: rtl/rategen_ch.sv
// One rate channel: down-counter, shadow/active divisor, optional fractional accumulator
// (built only when RATEGEN_FRAC_EN is defined).
module rategen_ch import rategen_pkg::*; #(
  parameter int CW       = 9,
  parameter int FW       = 8,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  input  logic [FW-1:0] wr_frac,
  output logic          rate
);
  logic [CW-1:0] active, shadow, cnt, wr_clamp, nxt_div;
  logic          pend, tc, reload, carry;

  assign wr_clamp = (wr_div < CW'(DIV_MIN)) ? CW'(DIV_MIN) : wr_div;
  assign tc       = en & (cnt == '0);
  assign reload   = sync | tc;
  // pend marks a shadow value not yet applied; a write landing on a reload stays pending
  assign nxt_div  = pend ? shadow : active;

`ifdef RATEGEN_FRAC_EN
  logic [FW-1:0] fshadow, factive, acc, nxt_frac;
  logic [FW:0]   fsum;

  assign nxt_frac = pend ? fshadow : factive;
  assign fsum     = {1'b0, acc} + {1'b0, nxt_frac};
  assign carry    = fsum[FW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fshadow <= '0;
      factive <= '0;
      acc     <= '0;
    end else begin
      if (wr) fshadow <= wr_frac;
      if (reload) begin
        factive <= nxt_frac;
        acc     <= fsum[FW-1:0];
      end
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^wr_frac;
  assign carry       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= CW'(DIV_INIT);
      shadow <= CW'(DIV_INIT);
      cnt    <= CW'(DIV_INIT - 1);
      pend   <= 1'b0;
      rate   <= 1'b0;
    end else begin
      rate <= tc & ~sync;
      if (reload) begin
        active <= nxt_div;
        cnt    <= nxt_div - CW'(1) + CW'(carry);
      end else if (en) begin
        cnt <= cnt - CW'(1);
      end
      if (wr) shadow <= wr_clamp;
      pend <= wr | (pend & ~reload);
    end
  end
endmodule

// File: rtl/rategen_mc.sv
// Multi-channel sample-rate strobe generator; NCH rategen_ch instances plus write decode.
// Optional fractional periods: define RATEGEN_FRAC_EN.
module rategen_mc import rategen_pkg::*; #(
  parameter int NCH      = 2,
  parameter int CW       = 9,
  parameter int DIV_INIT = DIV_INIT_DEF,
  parameter int FW       = 8
) (
  input  logic      clk,
  input  logic      reset,
  rategen_if.slave  bus
);
  logic [NCH-1:0] rate_w;

  // div_ch values at or above NCH match no instance and are dropped
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rategen_ch #(.CW(CW), .FW(FW), .DIV_INIT(DIV_INIT)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (bus.en[g]),
      .sync    (bus.sync),
      .wr      (bus.div_wr && (bus.div_ch == CHW'(g))),
      .wr_div  (bus.div_val),
      .wr_frac (bus.div_frac),
      .rate    (rate_w[g])
    );
  end

  assign bus.rate = rate_w;
endmodule

// File: doc/rategen_mc.md
RATEGEN_MC -- requirements
Module: rategen_mc

Interface
REQ-001 Parameter NCH, default 2: number of independent rate channels (1..8).
REQ-002 Parameter CW, default 9: divisor/counter width in bits.
REQ-003 Parameter DIV_INIT, default 384: divisor loaded into every channel at reset.
REQ-004 Parameter FW, default 8: fractional accumulator width.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 en  input  NCH  per-channel count enable.
REQ-008 sync  input  1  one-cycle pulse; realigns all channels.
REQ-009 div_wr  input  1  divisor write strobe.
REQ-010 div_ch  input  3  target channel of write; values >= NCH are ignored.
REQ-011 div_val  input  CW  new integer divisor.
REQ-012 div_frac  input  FW  new fractional divisor part; used only with RATEGEN_FRAC_EN.
REQ-013 rate  output  NCH  per-channel one-cycle sample-rate strobe, registered.

Function
REQ-014 Each channel holds: active divisor, shadow divisor, down-counter cnt (CW bits) and registered rate bit.
REQ-015 Enabled channel: cnt == 0 -> cnt <= active_div-1, rate <= 1 next cycle; otherwise cnt <= cnt-1, rate <= 0.
REQ-016 Period = active divisor clocks; pulse width exactly 1 clock; from reset release with en high, first pulse appears DIV_INIT clocks later.
REQ-017 en low: cnt holds, rate <= 0; re-asserting en resumes from held count with no extra pulse.
REQ-018 div_wr writes the shadow only; the shadow copies to active at the next reload (terminal count or sync), so no shortened or doubled period occurs.
REQ-019 Divisor values 0 and 1 are clamped to 2 at shadow write.
REQ-020 Multiple writes before a reload: the last one wins.
REQ-021 sync: all channels (enabled or not) reload cnt <= active_div-1 using the freshly applied shadow; rate <= 0 in that cycle.
REQ-022 sync coincident with terminal count: sync wins; no pulse is emitted.
REQ-023 div_wr coincident with a reload of the same channel: the new value takes effect at the following reload.

Reset
REQ-024 While reset is low: all active and shadow divisors = DIV_INIT, cnt = DIV_INIT-1, rate = 0, fractional accumulators = 0.
REQ-025 Reset asserted mid-period aborts the period immediately; inputs are ignored while reset is low.

Configuration
REQ-026 Macro RATEGEN_FRAC_EN defined: each channel adds an FW-bit accumulator; at each reload acc <= acc + frac; a carry lengthens that next period by one clock, giving an average period of div + frac/2^FW.
REQ-027 Macro RATEGEN_FRAC_EN undefined: div_frac is ignored, no accumulator is built, and periods are strictly integer.

Structure
REQ-028 Shared package rategen_pkg: DIV_INIT default, the minimum-divisor constant 2, and the channel-index width.
REQ-029 Sub-module rategen_ch implements one channel (counter, shadow, optional accumulator); rategen_mc instantiates NCH copies and decodes div_wr/div_ch.

Verification
REQ-030 Reset release with en=2'b11 and defaults -> rate[0] and rate[1] pulse at clocks 384, 768, 1152, each 1 clock wide.
REQ-031 Write div_val=100 to ch1 mid-period -> the current 384 period completes, then ch1 period = 100; ch0 is unaffected.
REQ-032 sync in the same cycle as ch0 terminal count -> no ch0 pulse; next ch0 pulse 384 clocks after sync.
REQ-033 en[0] low for 50 clocks mid-period -> the next ch0 pulse is delayed by exactly 50 clocks.
REQ-034 Write div_val=1 -> period = 2 after the next reload; div_ch=5 with NCH=2 -> no change.
REQ-035 RATEGEN_FRAC_EN with div=10 and frac=0x80 -> periods alternate 10/11; average 10.5 over 16 pulses.
